// File: rtl/bcd_display_ctrl.sv
// bcd_display_ctrl
//   Accepts an unsigned binary value through a valid/busy handshake and converts it
//   to BCD one bit per clock using shift-add-3. It then drives a time-multiplexed,
//   common-anode seven-segment display with DIGITS digits. The last committed value
//   stays in a display register while later conversions run, so the display does
//   not flicker. Values too large for the display show a dash on every digit.
//
// Ports
//   clk        in   1        system clock, rising edge
//   rst        in   1        asynchronous, active-high reset
//   num_valid  in   1        load num for conversion (accepted only while busy=0)
//   num        in   NUM_W    unsigned binary value to display
//   busy       out  1        conversion in progress
//   overflow   out  1        committed value was >= 10**DIGITS
//   Anode      out  DIGITS   digit enables, active-low, [0] = least significant digit
//   LED_out    out  7        segments {a,b,c,d,e,f,g}, active-low

module bcd_display_ctrl #(
    parameter int DIGITS      = 4,
    parameter int NUM_W       = 14,
    parameter int REFRESH_DIV = 262144,
    parameter int BLANK_LZ    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              num_valid,
    input  logic [NUM_W-1:0]  num,
    output logic              busy,
    output logic              overflow,
    output logic [DIGITS-1:0] Anode,
    output logic [6:0]        LED_out
);

    localparam int          BCD_W = 4 * DIGITS;
    localparam int          CNT_W = $clog2(NUM_W + 1);
    localparam int          REF_W = $clog2(REFRESH_DIV);
    localparam int          IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [31:0] LIMIT = 32'(10 ** DIGITS);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t             state_q;
    logic [NUM_W-1:0]   bin_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [BCD_W-1:0]   bcd_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_c_q;
    logic               busy_q;
    logic               overflow_q;
    logic [BCD_W-1:0]   disp_q;
    logic [REF_W-1:0]   ref_q;
    logic [IDX_W-1:0]   idx_q;
    logic [DIGITS-1:0]  anode_q;
    logic [DIGITS-1:0]  anode_d;
    logic [6:0]         led_q;
    logic [6:0]         led_d;
    logic [DIGITS-1:0]  blank_v;
    logic               zero_run;
    logic               ovf_in;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    seg7 = 7'b0000001;
            4'd1:    seg7 = 7'b1001111;
            4'd2:    seg7 = 7'b0010010;
            4'd3:    seg7 = 7'b0000110;
            4'd4:    seg7 = 7'b1001100;
            4'd5:    seg7 = 7'b0100100;
            4'd6:    seg7 = 7'b0100000;
            4'd7:    seg7 = 7'b0001111;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0000100;
            default: seg7 = 7'b1111110;
        endcase
    endfunction

    assign ovf_in = (32'(num) >= LIMIT);

    // Add-3 correction applied to every nibble before the shift.
    always_comb begin
        bcd_d = bcd_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    // Conversion FSM. Overflowing values skip the shift phase entirely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_c_q    <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            disp_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (num_valid) begin
                        bin_q   <= num;
                        bcd_q   <= '0;
                        cnt_q   <= CNT_W'(NUM_W);
                        ovf_c_q <= ovf_in;
                        busy_q  <= 1'b1;
                        state_q <= ovf_in ? COMMIT : SHIFT;
                    end
                end
                SHIFT: begin
                    // The top bit of the corrected BCD drops out; it is always zero
                    // for values below 10**DIGITS.
                    bcd_q <= BCD_W'({bcd_d, bin_q[NUM_W-1]});
                    bin_q <= bin_q << 1;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1))
                        state_q <= COMMIT;
                end
                COMMIT: begin
                    // All-ones nibbles decode to dashes on every digit.
                    disp_q     <= ovf_c_q ? '1 : bcd_q;
                    overflow_q <= ovf_c_q;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Leading-zero blanking: scan from the most significant digit down.
    always_comb begin
        zero_run = 1'b1;
        blank_v  = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            zero_run = zero_run && (disp_q[4*(DIGITS-1-k) +: 4] == 4'd0);
            blank_v[DIGITS-1-k] = zero_run && (k != DIGITS - 1) && (BLANK_LZ != 0);
        end
    end

    always_comb begin
        anode_d        = '1;
        anode_d[idx_q] = 1'b0;
        led_d          = blank_v[idx_q] ? 7'b1111111 : seg7(disp_q[4*idx_q +: 4]);
    end

    // Scan timing runs independently of the conversion FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_q   <= '0;
            idx_q   <= '0;
            anode_q <= ~DIGITS'(1);
            led_q   <= 7'b0000001;
        end else begin
            if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
                ref_q <= '0;
                idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
            end else begin
                ref_q <= ref_q + REF_W'(1);
            end
            anode_q <= anode_d;
            led_q   <= led_d;
        end
    end

    assign busy     = busy_q;
    assign overflow = overflow_q;
    assign Anode    = anode_q;
    assign LED_out  = led_q;

endmodule
